rx_slicer: RTL and testbench
============================

# rx_slicer

Decision slicer and margin monitor closing the receiver DFE loop. Each sampled UI, it subtracts the DFE correction (the signed ROM output of `rx_dfe`) from the channel-filter output and slices the difference to a bit. It registers that bit, which drives `rx_dfe.in` and the downstream data path. A windowed monitor reports the minimum vertical eye margin |sum| seen over each window.

## Interface
- `IN_WIDTH`, default 18: width of signed filter sample `filt_in`.
- `DFE_WIDTH`, default 18: width of signed DFE correction `dfe_in`; matches `DFE_OUT_WIDTH`.
- `WIN_LOG2`, default 10: margin window length is 2^WIN_LOG2 samples.
- `clk`, in, 1: single clock; one UI per enabled edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sample_en`, in, 1: sample qualifier; tied high in the system (one UI per `clk`); low = hold all state.
- `filt_in`, in, signed IN_WIDTH: filter output at the sampling instant.
- `dfe_in`, in, signed DFE_WIDTH: DFE correction for the current UI from `rx_dfe.out`.
- `margin_en`, in, 1: enables margin windows.
- `data_out`, out, 1: registered decision; feeds `rx_dfe.in`.
- `data_valid`, out, 1: one-cycle pulse, the cycle after each accepted sample.
- `margin_min`, out, SUM_W unsigned: minimum |sum| of the last completed window.
- `margin_valid`, out, 1: one-cycle pulse when `margin_min` updates.

## Operation
- SUM_W = max(IN_WIDTH, DFE_WIDTH) + 1.
- sum = sext(filt_in) − sext(dfe_in) in SUM_W bits; exact, no saturation, no wrap.
- Decision: 1 if sum ≥ 0, else 0. sum == 0 slices to 1.
- |sum| is computed as SUM_W-bit unsigned; the most negative sum fits without overflow.
- Decision register loads only when `sample_en` = 1.
  - `data_out` therefore holds decision n−1 while sample n is sliced.
  - This is the first-tap alignment `rx_dfe` requires.
- Margin FSM has two states, IDLE and ACCUM.
  - IDLE: `cnt` = 0, `run_min` = all-ones.
    - IDLE→ACCUM when `margin_en` = 1; this edge consumes no sample.
  - ACCUM, on each `sample_en`:
    - `run_min` ← min(`run_min`, |sum|).
    - `cnt` ← `cnt` + 1.
  - ACCUM, on the sample where `cnt` = 2^WIN_LOG2 − 1:
    - `margin_min` ← min(`run_min`, |sum|), with the final sample included.
    - `margin_valid` pulses on the next cycle.
    - `run_min` resets to all-ones and `cnt` wraps to 0.
    - If `margin_en` is still 1, stay in ACCUM with no lost sample; otherwise go to IDLE.
  - ACCUM, `margin_en` = 0 before the window completes:
    - Abort to IDLE and discard the partial window.
    - `margin_min` is unchanged; no pulse.
  - `margin_en` is sampled every cycle, independent of `sample_en`.
  - Window completion and an abort in the same cycle: completion wins and the result is reported.

## Timing
- Reset (async on `rst_n` = 0, held until release):
  - `data_out` = 0, `data_valid` = 0.
  - `margin_min` = all-ones, `margin_valid` = 0.
  - FSM in IDLE, `cnt` = 0.
- `data_out`, `data_valid`: latency 1 cycle from the `sample_en` edge.
- `margin_valid`: asserted 1 cycle after the final sample of the window, for exactly 1 cycle, coincident with the new `margin_min`.
- Combinational path: `rx_dfe` → `dfe_in` → subtract → compare → `data_out` D input.
  - This is the critical loop; no pipelining is permitted inside it.
- Reset asserted mid-window: the window is discarded; after release the FSM restarts from IDLE.
- `sample_en` = 0: all registers hold, and neither pulse is emitted.

## Structure
- Shared `rx_package` additions:
  - `SLICER_SUM_WIDTH`.
  - `MARGIN_WIN_LOG2`.
  - typedef `SLICER_SUM_FORMAT` (signed SUM_W).
  - typedef `MARGIN_FORMAT` (unsigned SUM_W).
- Sub-module `rx_margin_mon` holds the FSM, `cnt`, `run_min`, `margin_min` and `margin_valid`; its input is (|sum|, `sample_en`, `margin_en`).
- The top level keeps the subtractor, slicer and decision register.

## Test plan
All scenarios use IN_WIDTH = 8, DFE_WIDTH = 8, WIN_LOG2 = 2.
- Basic slice: `filt_in` = 5, `dfe_in` = 3 (sum 2) → `data_out` = 1 and `data_valid` pulse one cycle later. Then `filt_in` = −4, `dfe_in` = 0 → `data_out` = 0.
- Width extremes: `filt_in` = −128, `dfe_in` = 127 → sum −255, `data_out` = 0, no wrap. Zero case: `filt_in` = 7, `dfe_in` = 7 → `data_out` = 1.
- Window: `margin_en` = 1, four samples with sums 10, −3, 7, −20 → `margin_min` = 3 and a single `margin_valid` pulse the cycle after the 4th sample. The next window of 6, 6, 6, −6 → 6, back-to-back with no gap.
- Abort: `margin_en` dropped after 2 samples → no pulse, `margin_min` retains its prior value, FSM returns to IDLE.
- Stall: `sample_en` = 0 for 3 cycles mid-window → `cnt`, `data_out` and the window unaffected; the result matches the unstalled run.
- Async reset: `rst_n` pulsed low mid-window, off a clock edge → all outputs reach reset values immediately; the first window after release reports only post-reset samples.

Source files
------------

// File: rtl/rx_slicer_pkg.sv
// Shared receiver definitions for the decision slicer and margin monitor.
// Sum/margin formats are sized for the default 18-bit datapath.
package rx_slicer_pkg;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int SLICER_SUM_WIDTH = max_w(18, 18) + 1;
    localparam int MARGIN_WIN_LOG2 = 10;

    typedef logic signed [SLICER_SUM_WIDTH-1:0] SLICER_SUM_FORMAT;
    typedef logic [SLICER_SUM_WIDTH-1:0] MARGIN_FORMAT;

    typedef enum logic {
        M_IDLE,
        M_ACCUM
    } margin_state_t;

endpackage

// File: rtl/rx_slicer_margin_mon.sv
// Windowed minimum-|sum| eye margin monitor.
// A window closes after 2^WIN_LOG2 accepted samples.
module rx_margin_mon
    import rx_slicer_pkg::*;
#(
    parameter int SUM_W    = SLICER_SUM_WIDTH,
    parameter int WIN_LOG2 = MARGIN_WIN_LOG2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic             margin_en,
    input  logic [SUM_W-1:0] mag,
    output logic [SUM_W-1:0] margin_min,
    output logic             margin_valid
);

    localparam logic [WIN_LOG2-1:0] LAST = '1;

    margin_state_t       state;
    logic [WIN_LOG2-1:0] cnt;
    logic [SUM_W-1:0]    run_min;
    logic [SUM_W-1:0]    next_min;

    assign next_min = (mag < run_min) ? mag : run_min;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= M_IDLE;
            cnt          <= '0;
            run_min      <= '1;
            margin_min   <= '1;
            margin_valid <= 1'b0;
        end else begin
            margin_valid <= 1'b0;
            unique case (state)
                M_IDLE: begin
                    cnt     <= '0;
                    run_min <= '1;
                    if (margin_en) state <= M_ACCUM;
                end
                M_ACCUM: begin
                    // Completion outranks a simultaneous abort.
                    if (sample_en && cnt == LAST) begin
                        margin_min   <= next_min;
                        margin_valid <= 1'b1;
                        run_min      <= '1;
                        cnt          <= '0;
                        if (!margin_en) state <= M_IDLE;
                    end else if (!margin_en) begin
                        state   <= M_IDLE;
                        cnt     <= '0;
                        run_min <= '1;
                    end else if (sample_en) begin
                        run_min <= next_min;
                        cnt     <= cnt + WIN_LOG2'(1);
                    end
                end
                default: state <= M_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rx_slicer.sv
// Decision slicer closing the DFE loop: slice filt_in - dfe_in to a bit.
// The subtract/compare path into data_out is the unpipelined DFE loop.
module rx_slicer
    import rx_slicer_pkg::*;
#(
    parameter int IN_WIDTH  = 18,
    parameter int DFE_WIDTH = 18,
    parameter int WIN_LOG2  = MARGIN_WIN_LOG2,
    localparam int SUM_W    = max_w(IN_WIDTH, DFE_WIDTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sample_en,
    input  logic signed [IN_WIDTH-1:0]  filt_in,
    input  logic signed [DFE_WIDTH-1:0] dfe_in,
    input  logic                        margin_en,
    output logic                        data_out,
    output logic                        data_valid,
    output logic [SUM_W-1:0]            margin_min,
    output logic                        margin_valid
);

    logic signed [SUM_W-1:0] sum;
    logic [SUM_W-1:0]        mag;

    assign sum = SUM_W'(filt_in) - SUM_W'(dfe_in);
    assign mag = sum[SUM_W-1] ? $unsigned(-sum) : $unsigned(sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= sample_en;
            if (sample_en) data_out <= ~sum[SUM_W-1];
        end
    end

    rx_margin_mon #(
        .SUM_W   (SUM_W),
        .WIN_LOG2(WIN_LOG2)
    ) u_margin (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_en   (sample_en),
        .margin_en   (margin_en),
        .mag         (mag),
        .margin_min  (margin_min),
        .margin_valid(margin_valid)
    );

endmodule

// File: tb/tb_rx_slicer.sv
// Bench for rx_slicer: directed scenarios plus randomized run vs a queue model.
// Built with 8-bit inputs and 4-sample margin windows.
module tb_rx_slicer;

    localparam int IW  = 8;
    localparam int DW  = 8;
    localparam int WL  = 2;
    localparam int SW  = 9;
    localparam int WIN = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 sample_en = 1'b0;
    logic                 margin_en = 1'b0;
    logic signed [IW-1:0] filt_in = '0;
    logic signed [DW-1:0] dfe_in = '0;
    logic                 data_out;
    logic                 data_valid;
    logic [SW-1:0]        margin_min;
    logic                 margin_valid;

    int n_checks = 0;
    int n_fail = 0;

    bit m_data, m_dv, m_mv, m_active;
    int m_min;
    int m_q[$];

    rx_slicer #(
        .IN_WIDTH (IW),
        .DFE_WIDTH(DW),
        .WIN_LOG2 (WL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_en   (sample_en),
        .filt_in     (filt_in),
        .dfe_in      (dfe_in),
        .margin_en   (margin_en),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .margin_min  (margin_min),
        .margin_valid(margin_valid)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_data = 0; m_dv = 0; m_mv = 0; m_active = 0;
        m_min = 511;
        m_q.delete();
    endtask

    // Window model: collect |sum| of accepted samples, report min of each 4.
    task automatic model_step(input int s, input bit se, input bit me);
        int a, mn;
        a = (s < 0) ? -s : s;
        m_dv = se;
        m_mv = 0;
        if (se) m_data = (s >= 0);
        if (!m_active) begin
            m_active = me;
            m_q.delete();
        end else if (se && m_q.size() == WIN - 1) begin
            m_q.push_back(a);
            mn = 511;
            foreach (m_q[i]) if (m_q[i] < mn) mn = m_q[i];
            m_min = mn;
            m_mv = 1;
            m_q.delete();
            m_active = me;
        end else if (!me) begin
            m_active = 0;
            m_q.delete();
        end else if (se) begin
            m_q.push_back(a);
        end
    endtask

    task automatic step(input int f, input int d, input bit se, input bit me);
        @(negedge clk);
        filt_in = IW'(f);
        dfe_in = DW'(d);
        sample_en = se;
        margin_en = me;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(f - d, se, me);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({data_out, data_valid, margin_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000", {data_out, data_valid, margin_valid});
        end
        n_checks++;
        if (margin_min !== 9'h1FF) begin
            n_fail++;
            $display("FAIL reset_min: got %h want 1ff", margin_min);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_slice();
        step(5, 3, 1, 0);
        n_checks++;
        if (data_out !== 1'b1 || data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_pos: got d=%b v=%b want d=1 v=1", data_out, data_valid);
        end
        step(-4, 0, 1, 0);
        n_checks++;
        if (data_out !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_neg: got %b want 0", data_out);
        end
        step(50, 0, 0, 0);
        n_checks++;
        if (data_out !== 1'b0 || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_hold: got d=%b v=%b want d=0 v=0", data_out, data_valid);
        end
    endtask

    task automatic test_width_extremes();
        step(127, -128, 1, 0);
        n_checks++;
        if (data_out !== 1'b1) begin
            n_fail++;
            $display("FAIL ext_pos255: got %b want 1", data_out);
        end
        step(-128, 127, 1, 0);
        n_checks++;
        if (data_out !== 1'b0) begin
            n_fail++;
            $display("FAIL ext_neg255: got %b want 0", data_out);
        end
        step(7, 7, 1, 0);
        n_checks++;
        if (data_out !== 1'b1) begin
            n_fail++;
            $display("FAIL ext_zero: got %b want 1", data_out);
        end
    endtask

    task automatic test_window();
        int s1[4] = '{10, -3, 7, -20};
        int s2[4] = '{6, 6, 6, -6};
        int s3[4] = '{9, 8, -8, 9};
        step(0, 0, 1, 1);
        foreach (s1[i]) begin
            step(s1[i], 0, 1, 1);
            n_checks++;
            if (margin_valid !== (i == 3)) begin
                n_fail++;
                $display("FAIL win1_valid[%0d]: got %b want %b", i, margin_valid, i == 3);
            end
        end
        n_checks++;
        if (margin_min !== 9'd3) begin
            n_fail++;
            $display("FAIL win1_min: got %0d want 3", margin_min);
        end
        foreach (s2[i]) begin
            step(s2[i], 0, 1, 1);
            n_checks++;
            if (margin_valid !== (i == 3)) begin
                n_fail++;
                $display("FAIL win2_valid[%0d]: got %b want %b", i, margin_valid, i == 3);
            end
        end
        n_checks++;
        if (margin_min !== 9'd6) begin
            n_fail++;
            $display("FAIL win2_min: got %0d want 6", margin_min);
        end
        step(5, 0, 1, 1);
        step(5, 0, 1, 1);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        n_checks++;
        if (margin_valid !== 1'b0 || margin_min !== 9'd6) begin
            n_fail++;
            $display("FAIL abort: got v=%b min=%0d want v=0 min=6", margin_valid, margin_min);
        end
        // Fresh window after abort; last sample drops margin_en.
        step(0, 0, 1, 1);
        foreach (s3[i]) begin
            step(s3[i], 0, 1, i != 3);
            n_checks++;
            if (margin_valid !== (i == 3)) begin
                n_fail++;
                $display("FAIL win3_valid[%0d]: got %b want %b", i, margin_valid, i == 3);
            end
        end
        n_checks++;
        if (margin_min !== 9'd8) begin
            n_fail++;
            $display("FAIL win3_min: got %0d want 8", margin_min);
        end
    endtask

    task automatic test_stall();
        step(0, 0, 1, 1);
        step(10, 0, 1, 1);
        step(-4, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            n_checks++;
            if ({data_out, data_valid, margin_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL stall[%0d]: got %b want 000", i, {data_out, data_valid, margin_valid});
            end
        end
        step(7, 0, 1, 1);
        step(-9, 0, 1, 0);
        n_checks++;
        if (margin_valid !== 1'b1 || margin_min !== 9'd4) begin
            n_fail++;
            $display("FAIL stall_result: got v=%b min=%0d want v=1 min=4", margin_valid, margin_min);
        end
    endtask

    task automatic test_async_reset();
        int s[4] = '{9, -5, 8, 12};
        step(0, 0, 1, 1);
        step(-1, 0, 1, 1);
        step(3, 2, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({data_out, data_valid, margin_valid} !== 3'b000 || margin_min !== 9'h1FF) begin
            n_fail++;
            $display("FAIL async_rst: got d=%b v=%b mv=%b min=%h want 0 0 0 1ff",
                     data_out, data_valid, margin_valid, margin_min);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step(0, 0, 1, 1);
        foreach (s[i]) step(s[i], 0, 1, i != 3);
        n_checks++;
        if (margin_valid !== 1'b1 || margin_min !== 9'd5) begin
            n_fail++;
            $display("FAIL post_rst_win: got v=%b min=%0d want v=1 min=5", margin_valid, margin_min);
        end
    endtask

    task automatic test_random();
        int f, d;
        bit se, me;
        for (int i = 0; i < 400; i++) begin
            f = int'($urandom_range(0, 255)) - 128;
            d = (i % 3 == 0) ? f + int'($urandom_range(0, 10)) - 5
                             : int'($urandom_range(0, 255)) - 128;
            if (d > 127) d = 127;
            if (d < -128) d = -128;
            se = ($urandom_range(0, 9) != 0);
            me = ($urandom_range(0, 19) != 0);
            step(f, d, se, me);
            n_checks++;
            if (data_out !== m_data || data_valid !== m_dv) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: got d=%b v=%b want d=%b v=%b",
                         i, data_out, data_valid, m_data, m_dv);
            end
            n_checks++;
            if (margin_valid !== m_mv || margin_min !== SW'(m_min)) begin
                n_fail++;
                $display("FAIL rand_margin[%0d]: got v=%b min=%0d want v=%b min=%0d",
                         i, margin_valid, margin_min, m_mv, m_min);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_slice();
        test_width_extremes();
        test_window();
        test_stall();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
